// File: rtl/lc3b_mem_responder_if.sv
// LC-3b memory bus between a requester (datapath/control) and a memory-side responder.
// Signals:
//   mem_read / mem_write : request strobes, held by the requester until mem_resp
//   mem_byte_enable      : write byte lanes, [1] = bits 15:8, [0] = bits 7:0
//   mem_address          : byte address
//   mem_wdata            : write data
//   mem_rdata            : read data, held until the next read response
//   mem_resp             : one-cycle completion pulse
//   proto_err            : sticky protocol-violation flag
interface lc3b_mem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_resp;
  logic        proto_err;

  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_rdata, mem_resp, proto_err
  );

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_rdata, mem_resp, proto_err
  );
endinterface

// File: rtl/lc3b_mem_responder.sv
// Memory-side responder for the LC-3b memory bus. Serves reads and writes from an internal
// 2^ADDR_BITS x 16-bit word array after LATENCY cycles and returns a one-cycle mem_resp.
// Ports:
//   i_clk      : clock, all state on the rising edge
//   i_reset_n  : asynchronous active-low reset (array contents are kept)
//   bus        : slave side of lc3b_mem_responder_if
// Parameters:
//   ADDR_BITS  : word index width, index = mem_address[ADDR_BITS:1]
//   LATENCY    : cycles from request visible to mem_resp, 1..255
module lc3b_mem_responder #(
  parameter int unsigned ADDR_BITS = 12,
  parameter int unsigned LATENCY   = 3
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  lc3b_mem_responder_if.slave  bus
);

  localparam logic [7:0] LatM1 = 8'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp, StCool} state_e;

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic [7:0]             r_cnt;
  logic [7:0]             w_cnt_nxt;
  logic [ADDR_BITS-1:0]   r_idx;
  logic [15:0]            r_wdata;
  logic [1:0]             r_be;
  logic                   r_is_write;
  logic [15:0]            r_rdata;
  logic                   r_resp;
  logic                   r_err;
  logic [15:0]            r_mem [2**ADDR_BITS];

  logic                   w_req;
  logic                   w_accept;
  logic                   w_drop;
  logic                   w_go_resp;
  logic                   w_op_write;
  logic [ADDR_BITS-1:0]   w_op_idx;
  logic [15:0]            w_op_wdata;
  logic [1:0]             w_op_be;
  logic [ADDR_BITS-1:0]   w_in_idx;
  logic                   w_commit;
  logic                   w_unused_addr;

  assign w_req         = bus.mem_read | bus.mem_write;
  assign w_in_idx      = bus.mem_address[ADDR_BITS:1];
  assign w_unused_addr = ^{bus.mem_address[0], bus.mem_address[15:ADDR_BITS+1]};

  // With LATENCY=1 the RESP transition happens straight from IDLE, so the operation is
  // taken from the live inputs; otherwise the latched copy is used.
  assign w_op_write = (r_state == StIdle) ? bus.mem_write     : r_is_write;
  assign w_op_idx   = (r_state == StIdle) ? w_in_idx          : r_idx;
  assign w_op_wdata = (r_state == StIdle) ? bus.mem_wdata     : r_wdata;
  assign w_op_be    = (r_state == StIdle) ? bus.mem_byte_enable : r_be;

  // Reset gating keeps a clock edge during reset from committing a write.
  assign w_commit = w_go_resp & w_op_write & i_reset_n;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_drop      = 1'b0;
    w_go_resp   = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_req) begin
          w_accept = 1'b1;
          if (LATENCY == 1) begin
            w_state_nxt = StResp;
            w_cnt_nxt   = 8'd0;
            w_go_resp   = 1'b1;
          end else begin
            w_state_nxt = StBusy;
            w_cnt_nxt   = LatM1;
          end
        end
      end
      StBusy: begin
        if (!w_req) begin
          w_state_nxt = StIdle;
          w_cnt_nxt   = 8'd0;
          w_drop      = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
          if (w_cnt_nxt == 8'd0) begin
            w_state_nxt = StResp;
            w_go_resp   = 1'b1;
          end
        end
      end
      StResp:  w_state_nxt = StCool;
      StCool:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= StIdle;
      r_cnt      <= 8'd0;
      r_idx      <= '0;
      r_wdata    <= 16'h0000;
      r_be       <= 2'b00;
      r_is_write <= 1'b0;
      r_rdata    <= 16'h0000;
      r_resp     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_resp  <= w_go_resp;
      if (w_accept) begin
        r_idx      <= w_in_idx;
        r_wdata    <= bus.mem_wdata;
        r_be       <= bus.mem_byte_enable;
        r_is_write <= bus.mem_write;
        if (bus.mem_read && bus.mem_write) begin
          r_err <= 1'b1;
        end
      end
      if (w_drop) begin
        r_err <= 1'b1;
      end
      if (w_go_resp && !w_op_write) begin
        r_rdata <= r_mem[w_op_idx];
      end
    end
  end

  // Array is not reset so its contents survive reset.
  always_ff @(posedge i_clk) begin
    if (w_commit) begin
      if (w_op_be[0]) begin
        r_mem[w_op_idx][7:0] <= w_op_wdata[7:0];
      end
      if (w_op_be[1]) begin
        r_mem[w_op_idx][15:8] <= w_op_wdata[15:8];
      end
    end
  end

  assign bus.mem_rdata = r_rdata;
  assign bus.mem_resp  = r_resp;
  assign bus.proto_err = r_err;

endmodule

// File: tb/tb_lc3b_mem_responder.sv
module tb_lc3b_mem_responder;

  typedef struct {
    int          cyc;
    logic [15:0] rdata;
    bit          chk;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        tb_read;
  logic        tb_write;
  logic [1:0]  tb_be;
  logic [15:0] tb_addr;
  logic [15:0] tb_wdata;
  int          tb_sel;

  logic        obs_resp;
  logic [15:0] obs_rdata;
  logic        obs_err;

  int   n_checks;
  int   n_pass;
  exp_t sb[$];

  lc3b_mem_responder_if if3 ();
  lc3b_mem_responder_if if2 ();
  lc3b_mem_responder_if if1 ();

  lc3b_mem_responder #(.ADDR_BITS(12), .LATENCY(3)) u_dut3 (
    .i_clk(clk), .i_reset_n(reset_n), .bus(if3.slave)
  );
  lc3b_mem_responder #(.ADDR_BITS(12), .LATENCY(2)) u_dut2 (
    .i_clk(clk), .i_reset_n(reset_n), .bus(if2.slave)
  );
  lc3b_mem_responder #(.ADDR_BITS(12), .LATENCY(1)) u_dut1 (
    .i_clk(clk), .i_reset_n(reset_n), .bus(if1.slave)
  );

  // Shared stimulus steered to the selected instance.
  assign if3.mem_read        = tb_read  & (tb_sel == 3);
  assign if3.mem_write       = tb_write & (tb_sel == 3);
  assign if3.mem_byte_enable = tb_be;
  assign if3.mem_address     = tb_addr;
  assign if3.mem_wdata       = tb_wdata;
  assign if2.mem_read        = tb_read  & (tb_sel == 2);
  assign if2.mem_write       = tb_write & (tb_sel == 2);
  assign if2.mem_byte_enable = tb_be;
  assign if2.mem_address     = tb_addr;
  assign if2.mem_wdata       = tb_wdata;
  assign if1.mem_read        = tb_read  & (tb_sel == 1);
  assign if1.mem_write       = tb_write & (tb_sel == 1);
  assign if1.mem_byte_enable = tb_be;
  assign if1.mem_address     = tb_addr;
  assign if1.mem_wdata       = tb_wdata;

  always_comb begin
    obs_resp  = if3.mem_resp;
    obs_rdata = if3.mem_rdata;
    obs_err   = if3.proto_err;
    if (tb_sel == 2) begin
      obs_resp  = if2.mem_resp;
      obs_rdata = if2.mem_rdata;
      obs_err   = if2.proto_err;
    end else if (tb_sel == 1) begin
      obs_resp  = if1.mem_resp;
      obs_rdata = if1.mem_rdata;
      obs_err   = if1.proto_err;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one request starting at cycle 0 (called just after a rising edge), pushes the
  // expectation, waits for mem_resp, then releases the request and lets COOL pass.
  // Returns the response cycle (-1 on timeout), the rdata seen and mem_resp one cycle later.
  task automatic txn(input logic wr, input logic rd, input logic [1:0] be,
                     input logic [15:0] addr, input logic [15:0] wd,
                     input logic [15:0] exp_rd, input bit chk, input int exp_cyc,
                     output int cyc, output logic [15:0] rdata, output logic after);
    exp_t e;
    e.cyc = exp_cyc; e.rdata = exp_rd; e.chk = chk;
    sb.push_back(e);
    tb_write = wr; tb_read = rd; tb_be = be; tb_addr = addr; tb_wdata = wd;
    cyc = -1;
    rdata = 16'h0000;
    for (int i = 0; i < 20 && cyc < 0; i++) begin
      @(negedge clk);
      if (obs_resp === 1'b1) begin
        cyc = i;
        rdata = obs_rdata;
      end
    end
    @(posedge clk); #1;
    tb_read = 1'b0; tb_write = 1'b0;
    @(negedge clk);
    after = obs_resp;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (if3.mem_resp !== 1'b0) $display("FAIL reset_resp3 got %b want 0", if3.mem_resp);
    else n_pass++;
    n_checks++;
    if (if3.mem_rdata !== 16'h0000) $display("FAIL reset_rdata3 got %h want 0000", if3.mem_rdata);
    else n_pass++;
    n_checks++;
    if (if3.proto_err !== 1'b0) $display("FAIL reset_err3 got %b want 0", if3.proto_err);
    else n_pass++;
    n_checks++;
    if (if1.mem_resp !== 1'b0 || if2.mem_resp !== 1'b0)
      $display("FAIL reset_resp12 got %b%b want 00", if1.mem_resp, if2.mem_resp);
    else n_pass++;
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int cyc; logic [15:0] rd; logic after; exp_t e;
    tb_sel = 3;
    txn(1'b1, 1'b0, 2'b11, 16'h0010, 16'hBEEF, 16'h0000, 1'b0, 3, cyc, rd, after);
    e = sb.pop_front();
    n_checks++;
    if (cyc !== e.cyc) $display("FAIL wr_latency got %0d want %0d", cyc, e.cyc);
    else n_pass++;
    txn(1'b0, 1'b1, 2'b00, 16'h0010, 16'h0000, 16'hBEEF, 1'b1, 3, cyc, rd, after);
    e = sb.pop_front();
    n_checks++;
    if (cyc !== e.cyc) $display("FAIL rd_latency got %0d want %0d", cyc, e.cyc);
    else n_pass++;
    n_checks++;
    if (rd !== e.rdata) $display("FAIL rd_data got %h want %h", rd, e.rdata);
    else n_pass++;
    n_checks++;
    if (after !== 1'b0) $display("FAIL resp_width got %b want 0", after);
    else n_pass++;
    n_checks++;
    if (obs_err !== 1'b0) $display("FAIL err_clean got %b want 0", obs_err);
    else n_pass++;
    // Address bit 13 lies above the word index and must be ignored.
    txn(1'b0, 1'b1, 2'b00, 16'h2010, 16'h0000, 16'hBEEF, 1'b1, 3, cyc, rd, after);
    e = sb.pop_front();
    n_checks++;
    if (rd !== e.rdata) $display("FAIL high_addr_ignored got %h want %h", rd, e.rdata);
    else n_pass++;
  endtask

  task automatic test_byte_lanes();
    int cyc; logic [15:0] rd; logic after; exp_t e;
    tb_sel = 3;
    txn(1'b1, 1'b0, 2'b11, 16'h0040, 16'h1234, 16'h0000, 1'b0, 3, cyc, rd, after);
    e = sb.pop_front();
    txn(1'b1, 1'b0, 2'b10, 16'h0040, 16'hABCD, 16'h0000, 1'b0, 3, cyc, rd, after);
    e = sb.pop_front();
    txn(1'b0, 1'b1, 2'b00, 16'h0040, 16'h0000, 16'hAB34, 1'b1, 3, cyc, rd, after);
    e = sb.pop_front();
    n_checks++;
    if (rd !== e.rdata) $display("FAIL lane_hi got %h want %h", rd, e.rdata);
    else n_pass++;
    txn(1'b1, 1'b0, 2'b01, 16'h0040, 16'h00EF, 16'h0000, 1'b0, 3, cyc, rd, after);
    e = sb.pop_front();
    txn(1'b0, 1'b1, 2'b00, 16'h0040, 16'h0000, 16'hABEF, 1'b1, 3, cyc, rd, after);
    e = sb.pop_front();
    n_checks++;
    if (rd !== e.rdata) $display("FAIL lane_lo got %h want %h", rd, e.rdata);
    else n_pass++;
    txn(1'b1, 1'b0, 2'b00, 16'h0040, 16'h5555, 16'h0000, 1'b0, 3, cyc, rd, after);
    e = sb.pop_front();
    n_checks++;
    if (cyc !== e.cyc) $display("FAIL be00_resp got %0d want %0d", cyc, e.cyc);
    else n_pass++;
    txn(1'b0, 1'b1, 2'b00, 16'h0040, 16'h0000, 16'hABEF, 1'b1, 3, cyc, rd, after);
    e = sb.pop_front();
    n_checks++;
    if (rd !== e.rdata) $display("FAIL be00_unchanged got %h want %h", rd, e.rdata);
    else n_pass++;
  endtask

  task automatic test_latency1_alias();
    int cyc; logic [15:0] rd; logic after; exp_t e;
    tb_sel = 1;
    txn(1'b1, 1'b0, 2'b11, 16'h0020, 16'h5A5A, 16'h0000, 1'b0, 1, cyc, rd, after);
    e = sb.pop_front();
    n_checks++;
    if (cyc !== e.cyc) $display("FAIL l1_wr_latency got %0d want %0d", cyc, e.cyc);
    else n_pass++;
    txn(1'b1, 1'b0, 2'b11, 16'h0022, 16'h1111, 16'h0000, 1'b0, 1, cyc, rd, after);
    e = sb.pop_front();
    txn(1'b0, 1'b1, 2'b00, 16'h0021, 16'h0000, 16'h5A5A, 1'b1, 1, cyc, rd, after);
    e = sb.pop_front();
    n_checks++;
    if (cyc !== e.cyc) $display("FAIL l1_rd_latency got %0d want %0d", cyc, e.cyc);
    else n_pass++;
    n_checks++;
    if (rd !== e.rdata) $display("FAIL l1_alias got %h want %h", rd, e.rdata);
    else n_pass++;
    n_checks++;
    if (after !== 1'b0) $display("FAIL l1_resp_width got %b want 0", after);
    else n_pass++;
  endtask

  task automatic test_held_request();
    exp_t e;
    logic exp_resp;
    tb_sel = 2;
    e.rdata = 16'h0000; e.chk = 1'b0;
    e.cyc = 2; sb.push_back(e);
    e.cyc = 6; sb.push_back(e);
    tb_read = 1'b1; tb_write = 1'b0; tb_addr = 16'h0030; tb_be = 2'b00;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      exp_resp = (sb.size() > 0 && sb[0].cyc == i);
      n_checks++;
      if (obs_resp !== exp_resp) $display("FAIL held_c%0d got %b want %b", i, obs_resp, exp_resp);
      else n_pass++;
      if (exp_resp) e = sb.pop_front();
    end
    @(posedge clk); #1;
    tb_read = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) $display("FAIL held_sb_left got %0d want 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_drop_in_busy();
    int cyc; logic [15:0] rd; logic after; exp_t e;
    int resp_cnt;
    tb_sel = 3;
    tb_write = 1'b1; tb_read = 1'b0; tb_be = 2'b11; tb_addr = 16'h0010; tb_wdata = 16'hDEAD;
    @(posedge clk); #1;
    tb_write = 1'b0;
    resp_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (obs_resp === 1'b1) resp_cnt++;
    end
    n_checks++;
    if (resp_cnt != 0) $display("FAIL drop_resp got %0d want 0", resp_cnt);
    else n_pass++;
    n_checks++;
    if (obs_err !== 1'b1) $display("FAIL drop_err got %b want 1", obs_err);
    else n_pass++;
    @(posedge clk); #1;
    txn(1'b0, 1'b1, 2'b00, 16'h0010, 16'h0000, 16'hBEEF, 1'b1, 3, cyc, rd, after);
    e = sb.pop_front();
    n_checks++;
    if (rd !== e.rdata) $display("FAIL drop_no_write got %h want %h", rd, e.rdata);
    else n_pass++;
    // Clear the sticky flag for the next scenario.
    reset_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs_err !== 1'b0) $display("FAIL err_reset got %b want 0", obs_err);
    else n_pass++;
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_rd_wr_both();
    int cyc; logic [15:0] rd; logic after; exp_t e;
    tb_sel = 3;
    txn(1'b1, 1'b1, 2'b11, 16'h0050, 16'h7777, 16'h0000, 1'b0, 3, cyc, rd, after);
    e = sb.pop_front();
    n_checks++;
    if (cyc !== e.cyc || after !== 1'b0)
      $display("FAIL both_single_resp got cyc=%0d after=%b want cyc=%0d after=0", cyc, after, e.cyc);
    else n_pass++;
    n_checks++;
    if (obs_err !== 1'b1) $display("FAIL both_err got %b want 1", obs_err);
    else n_pass++;
    txn(1'b0, 1'b1, 2'b00, 16'h0050, 16'h0000, 16'h7777, 1'b1, 3, cyc, rd, after);
    e = sb.pop_front();
    n_checks++;
    if (rd !== e.rdata) $display("FAIL both_written got %h want %h", rd, e.rdata);
    else n_pass++;
  endtask

  task automatic test_reset_mid_busy();
    int cyc; logic [15:0] rd; logic after; exp_t e;
    int resp_cnt;
    tb_sel = 3;
    tb_write = 1'b1; tb_read = 1'b0; tb_be = 2'b11; tb_addr = 16'h0010; tb_wdata = 16'hCAFE;
    @(posedge clk); #1;
    reset_n = 1'b0;
    tb_write = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs_resp !== 1'b0 || obs_rdata !== 16'h0000 || obs_err !== 1'b0)
      $display("FAIL rst_busy_outputs got resp=%b rdata=%h err=%b want 0/0000/0",
               obs_resp, obs_rdata, obs_err);
    else n_pass++;
    #1 reset_n = 1'b1;
    resp_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (obs_resp === 1'b1) resp_cnt++;
    end
    n_checks++;
    if (resp_cnt != 0) $display("FAIL rst_busy_resp got %0d want 0", resp_cnt);
    else n_pass++;
    @(posedge clk); #1;
    txn(1'b0, 1'b1, 2'b00, 16'h0010, 16'h0000, 16'hBEEF, 1'b1, 3, cyc, rd, after);
    e = sb.pop_front();
    n_checks++;
    if (rd !== e.rdata) $display("FAIL rst_busy_old_data got %h want %h", rd, e.rdata);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset_n  = 1'b0;
    tb_read  = 1'b0;
    tb_write = 1'b0;
    tb_be    = 2'b00;
    tb_addr  = 16'h0000;
    tb_wdata = 16'h0000;
    tb_sel   = 3;
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_latency1_alias();
    test_held_request();
    test_drop_in_busy();
    test_rd_wr_both();
    test_reset_mid_busy();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
